// File: rtl/ring_interlock_feedback.sv
// ring_interlock_feedback
// Downstream stage of the ring interlock logic (channels A..H). Each channel
// debounces its request/grant pair, enters ACTIVE through a round-robin
// arbiter that admits at most one channel per edge and never two neighbours,
// holds its feedback bit for a minimum time, and drops back to IDLE. A grant
// seen next to an active neighbour latches a sticky fault and drops every
// channel to IDLE.
//
// Optional build macro: RING_ILOCK_WATCHDOG_EN
//   Adds a per-channel residence watchdog that forces a channel to IDLE after
//   MAX_ACTIVE cycles in ACTIVE/RELEASE, pulses o_wd_trip[i] and locks the
//   channel out until its request is seen low. Without the macro there is no
//   o_wd_trip port and no watchdog logic.

module ring_interlock_feedback #(
    parameter int N_CH       = 8,
    parameter int DEBOUNCE   = 3,
    parameter int MIN_HOLD   = 16,
    parameter int CNT_W      = 8,
    parameter int MAX_ACTIVE = 200
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         i_req,
    input  logic [N_CH-1:0]         i_grant,
    input  logic                    i_fault_clr,
    output logic [N_CH-1:0]         o_fb,
    output logic                    o_busy,
    output logic                    o_fault,
    output logic [$clog2(N_CH)-1:0] o_fault_ch
`ifdef RING_ILOCK_WATCHDOG_EN
    ,
    output logic [N_CH-1:0]         o_wd_trip
`endif
);

    localparam int IDX_W    = $clog2(N_CH);
    localparam int CNT_CEIL = (1 << CNT_W) - 1;

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DEB_C   = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(MIN_HOLD);
`ifdef RING_ILOCK_WATCHDOG_EN
    localparam logic [CNT_W-1:0] MAXA_C  = CNT_W'(MAX_ACTIVE);
`endif

    // Counters must be able to represent every threshold they are compared to.
    generate
        if (N_CH < 2 || DEBOUNCE < 1 || MIN_HOLD < 1 || DEBOUNCE > CNT_CEIL ||
            MIN_HOLD > CNT_CEIL || MAX_ACTIVE < 1 || MAX_ACTIVE > CNT_CEIL) begin : g_bad_cfg
            $error("ring_interlock_feedback: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUAL    = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Per-channel views shared between the channel FSMs and the global logic.
    logic [N_CH-1:0]  q_vec;      // request qualified by grant
    logic [N_CH-1:0]  act_vec;    // channel in ACTIVE or RELEASE (pre-edge)
    logic [N_CH-1:0]  cand_vec;   // debounced and waiting to be admitted
    logic [N_CH-1:0]  elig_vec;   // neither neighbour is active
    logic [N_CH-1:0]  viol_vec;   // grant next to an active neighbour
    logic [N_CH-1:0]  win_oh;     // one-hot arbitration winner
    logic [N_CH-1:0]  fb_d;       // next feedback value per channel
    logic [N_CH-1:0]  busy_vec;   // next "not IDLE" per channel
`ifdef RING_ILOCK_WATCHDOG_EN
    logic [N_CH-1:0]  trip_d;
    logic [N_CH-1:0]  trip_q;
`endif

    logic             win_vld;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W:0]   scan_sum;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] rr_q, rr_d;

    logic             fault_now;
    logic [IDX_W-1:0] viol_idx;
    logic             fault_q, fault_d;
    logic [IDX_W-1:0] fault_ch_q, fault_ch_d;

    logic [N_CH-1:0]  fb_q;
    logic             busy_q;

    // ------------------------------------------------------------------
    // Per-channel qualification / hold state machines
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            localparam int LEFT  = (gi + N_CH - 1) % N_CH;
            localparam int RIGHT = (gi + 1) % N_CH;

            state_t           st_q, st_d;
            logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
            logic             entry_ok;

            assign q_vec[gi]    = i_req[gi] & i_grant[gi];
            assign act_vec[gi]  = (st_q == ST_ACTIVE) || (st_q == ST_RELEASE);
            assign cand_vec[gi] = (st_q == ST_QUAL) && q_vec[gi] && (cnt_q >= DEB_C);
            assign elig_vec[gi] = !act_vec[LEFT] && !act_vec[RIGHT];
            assign viol_vec[gi] = i_grant[gi] && !act_vec[gi] &&
                                  (act_vec[LEFT] || act_vec[RIGHT]);
            assign cnt_inc      = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

`ifdef RING_ILOCK_WATCHDOG_EN
            logic [CNT_W-1:0] wd_q, wd_d, wd_inc;
            logic             lock_q, lock_d, wd_hit;

            assign wd_inc      = (wd_q == CNT_SAT) ? wd_q : wd_q + 1'b1;
            assign wd_hit      = act_vec[gi] && (wd_inc >= MAXA_C);
            assign trip_d[gi]  = wd_hit && !fault_now;
            assign entry_ok    = !fault_q && !lock_q;
`else
            assign entry_ok    = !fault_q;
`endif

            // Next state: normal FSM, then watchdog, then fault override.
            always_comb begin
                st_d  = st_q;
                cnt_d = cnt_q;
                case (st_q)
                    ST_IDLE: begin
                        cnt_d = '0;
                        if (q_vec[gi] && entry_ok) begin
                            st_d  = ST_QUAL;
                            cnt_d = CNT_W'(1);
                        end
                    end
                    ST_QUAL: begin
                        if (!q_vec[gi]) begin
                            st_d  = ST_IDLE;
                            cnt_d = '0;
                        end else if (cnt_q < DEB_C) begin
                            cnt_d = cnt_inc;
                        end else if (win_oh[gi]) begin
                            st_d  = ST_ACTIVE;
                            cnt_d = '0;
                        end
                    end
                    ST_ACTIVE: begin
                        cnt_d = cnt_inc;
                        if (!i_req[gi]) begin
                            if (cnt_inc >= HOLD_C) begin
                                st_d  = ST_IDLE;
                                cnt_d = '0;
                            end else begin
                                st_d  = ST_RELEASE;
                            end
                        end
                    end
                    ST_RELEASE: begin
                        cnt_d = cnt_inc;
                        if (i_req[gi]) begin
                            // Resume without re-qualification; hold count keeps running.
                            st_d = ST_ACTIVE;
                        end else if (cnt_inc >= HOLD_C) begin
                            st_d  = ST_IDLE;
                            cnt_d = '0;
                        end
                    end
                    default: begin
                        st_d  = ST_IDLE;
                        cnt_d = '0;
                    end
                endcase
`ifdef RING_ILOCK_WATCHDOG_EN
                if (wd_hit) begin
                    st_d  = ST_IDLE;
                    cnt_d = '0;
                end
`endif
                if (fault_now) begin
                    st_d  = ST_IDLE;
                    cnt_d = '0;
                end
            end

`ifdef RING_ILOCK_WATCHDOG_EN
            // Residence counter runs only while the channel stays active; lockout
            // is armed by a trip and released by a low request.
            always_comb begin
                wd_d = '0;
                if (act_vec[gi] && ((st_d == ST_ACTIVE) || (st_d == ST_RELEASE))) begin
                    wd_d = wd_inc;
                end
                lock_d = lock_q;
                if (trip_d[gi]) begin
                    lock_d = 1'b1;
                end else if (!i_req[gi]) begin
                    lock_d = 1'b0;
                end
            end
`endif

            assign fb_d[gi]     = (st_d == ST_ACTIVE) || (st_d == ST_RELEASE);
            assign busy_vec[gi] = (st_d != ST_IDLE);

            // Channel state registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    st_q   <= ST_IDLE;
                    cnt_q  <= '0;
`ifdef RING_ILOCK_WATCHDOG_EN
                    wd_q   <= '0;
                    lock_q <= 1'b0;
`endif
                end else begin
                    st_q   <= st_d;
                    cnt_q  <= cnt_d;
`ifdef RING_ILOCK_WATCHDOG_EN
                    wd_q   <= wd_d;
                    lock_q <= lock_d;
`endif
                end
            end
        end
    endgenerate

    // Round-robin arbiter: first eligible candidate scanning upward from rr.
    always_comb begin
        win_oh   = '0;
        win_vld  = 1'b0;
        win_idx  = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            scan_sum = {1'b0, rr_q} + (IDX_W + 1)'(k);
            if (scan_sum >= (IDX_W + 1)'(N_CH)) begin
                scan_sum = scan_sum - (IDX_W + 1)'(N_CH);
            end
            scan_idx = scan_sum[IDX_W-1:0];
            if (!win_vld && cand_vec[scan_idx] && elig_vec[scan_idx]) begin
                win_vld          = 1'b1;
                win_idx          = scan_idx;
                win_oh[scan_idx] = 1'b1;
            end
        end
    end

    // Fault detection with lowest-index priority, sticky flag and pointer update.
    always_comb begin
        viol_idx = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (viol_vec[k]) begin
                viol_idx = IDX_W'(k);
            end
        end
        fault_now = |viol_vec;

        fault_d    = fault_q;
        fault_ch_d = fault_ch_q;
        if (fault_now) begin
            // A fresh violation beats a simultaneous clear.
            fault_d = 1'b1;
            if (!fault_q) begin
                fault_ch_d = viol_idx;
            end
        end else if (i_fault_clr) begin
            fault_d = 1'b0;
        end

        rr_d = rr_q;
        if (win_vld && !fault_now) begin
            rr_d = (win_idx == IDX_W'(N_CH - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    // Global registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= '0;
            fault_q    <= 1'b0;
            fault_ch_q <= '0;
            fb_q       <= '0;
            busy_q     <= 1'b0;
`ifdef RING_ILOCK_WATCHDOG_EN
            trip_q     <= '0;
`endif
        end else begin
            rr_q       <= rr_d;
            fault_q    <= fault_d;
            fault_ch_q <= fault_ch_d;
            fb_q       <= fb_d;
            busy_q     <= |busy_vec;
`ifdef RING_ILOCK_WATCHDOG_EN
            trip_q     <= trip_d;
`endif
        end
    end

    assign o_fb       = fb_q;
    assign o_busy     = busy_q;
    assign o_fault    = fault_q;
    assign o_fault_ch = fault_ch_q;
`ifdef RING_ILOCK_WATCHDOG_EN
    assign o_wd_trip  = trip_q;
`endif

endmodule

// File: tb/tb_ring_interlock_feedback.sv
// Testbench for ring_interlock_feedback: directed scenarios followed by
// random traffic; a behavioural model predicts the registered outputs after
// each edge and a monitor compares them against the DUT one cycle at a time.

module tb_ring_interlock_feedback;

    localparam int N    = 8;
    localparam int DEB  = 3;
    localparam int HOLD = 16;
    localparam int MAXA = 20;
`ifdef RING_ILOCK_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_req = '0;
    logic [7:0] i_grant = '0;
    logic       i_fault_clr = 1'b0;
    logic [7:0] o_fb;
    logic       o_busy;
    logic       o_fault;
    logic [2:0] o_fault_ch;
`ifdef RING_ILOCK_WATCHDOG_EN
    logic [7:0] o_wd_trip;
`endif

    ring_interlock_feedback #(
        .N_CH(N), .DEBOUNCE(DEB), .MIN_HOLD(HOLD), .CNT_W(8), .MAX_ACTIVE(MAXA)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_req),
        .i_grant     (i_grant),
        .i_fault_clr (i_fault_clr),
        .o_fb        (o_fb),
        .o_busy      (o_busy),
        .o_fault     (o_fault),
        .o_fault_ch  (o_fault_ch)
`ifdef RING_ILOCK_WATCHDOG_EN
        ,
        .o_wd_trip   (o_wd_trip)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] req;
        logic [7:0] gnt;
        logic       clr;
        logic       rst;
        logic [7:0] fb;
        logic       busy;
        logic       fault;
        logic [2:0] fch;
        logic [7:0] trip;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: a channel is either "on" (feedback high) with an age
    // since admission, or off with a streak of consecutive qualified cycles.
    bit m_on     [N];
    int m_age    [N];
    int m_streak [N];
    bit m_lock   [N];
    int m_rr;
    bit m_fault;
    int m_fch;
    bit [7:0] m_trip;

    function automatic int nb_lo(input int i); return (i + N - 1) % N; endfunction
    function automatic int nb_hi(input int i); return (i + 1) % N; endfunction

    task automatic model_step(input bit [7:0] req, input bit [7:0] gnt,
                              input bit clr, input bit r);
        bit       fnow;
        int       fj;
        bit       fault_pre;
        int       win;
        int       idx;
        bit       q;
        bit [7:0] trip_n;
        fnow   = 1'b0;
        fj     = 0;
        win    = -1;
        trip_n = '0;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                m_on[i] = 0; m_age[i] = 0; m_streak[i] = 0; m_lock[i] = 0;
            end
            m_rr = 0; m_fault = 0; m_fch = 0; m_trip = '0;
            return;
        end
        for (int j = N - 1; j >= 0; j--) begin
            if (gnt[j] && !m_on[j] && (m_on[nb_lo(j)] || m_on[nb_hi(j)])) begin
                fnow = 1'b1;
                fj   = j;
            end
        end
        if (fnow) begin
            if (!m_fault) m_fch = fj;
            m_fault = 1'b1;
            for (int i = 0; i < N; i++) begin
                m_on[i] = 0; m_age[i] = 0; m_streak[i] = 0;
                if (!req[i]) m_lock[i] = 0;
            end
            m_trip = '0;
            return;
        end
        fault_pre = m_fault;
        if (clr) m_fault = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (win < 0 && !m_on[idx] && req[idx] && gnt[idx] && m_streak[idx] >= DEB &&
                !m_on[nb_lo(idx)] && !m_on[nb_hi(idx)]) begin
                win = idx;
            end
        end
        for (int i = 0; i < N; i++) begin
            q = req[i] & gnt[i];
            if (m_on[i]) begin
                if (WD && (m_age[i] + 1 >= MAXA)) begin
                    m_on[i] = 0; m_age[i] = 0; trip_n[i] = 1'b1; m_lock[i] = 1'b1;
                end else if (!req[i] && (m_age[i] + 1 >= HOLD)) begin
                    m_on[i] = 0; m_age[i] = 0;
                end else begin
                    m_age[i] = m_age[i] + 1;
                end
            end else if (i == win) begin
                m_on[i] = 1; m_age[i] = 0; m_streak[i] = 0;
            end else if (!q) begin
                m_streak[i] = 0;
            end else if (m_streak[i] > 0 || (!fault_pre && !m_lock[i])) begin
                m_streak[i] = (m_streak[i] + 1 > DEB) ? DEB : m_streak[i] + 1;
            end
            if (!trip_n[i] && !req[i]) m_lock[i] = 1'b0;
        end
        if (win >= 0) m_rr = (win + 1) % N;
        m_trip = trip_n;
    endtask

    // Drive one cycle of inputs and queue the model's prediction for that edge.
    task automatic step(input logic [7:0] req, input logic [7:0] gnt,
                        input logic clr, input logic r);
        exp_t e;
        @(negedge clk);
        i_req = req; i_grant = gnt; i_fault_clr = clr; rst = r;
        model_step(req, gnt, clr, r);
        e.req = req; e.gnt = gnt; e.clr = clr; e.rst = r;
        e.fb = '0; e.busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            e.fb[i] = m_on[i];
            if (m_on[i] || m_streak[i] > 0) e.busy = 1'b1;
        end
        e.fault = m_fault;
        e.fch   = 3'(m_fch);
        e.trip  = m_trip;
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic rep(input logic [7:0] req, input logic [7:0] gnt,
                       input logic clr, input logic r, input int n);
        for (int k = 0; k < n; k++) step(req, gnt, clr, r);
    endtask

    // Monitor: compare DUT outputs shortly after each edge with the queued prediction.
    initial begin
        exp_t e;
        int   mcyc;
        mcyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                mcyc++;
                total++;
                if (o_fb !== e.fb) begin
                    bad++;
                    $display("FAIL fb cyc=%0d got=%h want=%h", mcyc, o_fb, e.fb);
                end
                total++;
                if (o_busy !== e.busy) begin
                    bad++;
                    $display("FAIL busy cyc=%0d got=%b want=%b", mcyc, o_busy, e.busy);
                end
                total++;
                if (o_fault !== e.fault) begin
                    bad++;
                    $display("FAIL fault cyc=%0d got=%b want=%b", mcyc, o_fault, e.fault);
                end
                total++;
                if (o_fault_ch !== e.fch) begin
                    bad++;
                    $display("FAIL fault_ch cyc=%0d got=%0d want=%0d", mcyc, o_fault_ch, e.fch);
                end
`ifdef RING_ILOCK_WATCHDOG_EN
                total++;
                if (o_wd_trip !== e.trip) begin
                    bad++;
                    $display("FAIL wd_trip cyc=%0d got=%h want=%h", mcyc, o_wd_trip, e.trip);
                end
`endif
                $display("cyc=%0d rst=%b req=%h gnt=%h clr=%b -> fb=%h busy=%b fault=%b ch=%0d",
                         mcyc, e.rst, e.req, e.gnt, e.clr, o_fb, o_busy, o_fault, o_fault_ch);
            end
        end
    end

    initial begin
        logic [7:0] rq;
        logic [7:0] gn;
        logic       cl;
        logic       rr;
        logic [2:0] pick;

        // Reset with all requests and grants high.
        rep(8'hFF, 8'hFF, 1'b0, 1'b1, 2);
        // All qualify together; channel 0 is admitted first.
        rep(8'hFF, 8'hFF, 1'b0, 1'b0, 4);
        rep(8'h01, 8'h00, 1'b0, 1'b0, 3);
        rep(8'h00, 8'h00, 1'b0, 1'b0, 20);
        // Two-cycle grant glitch on channel 1 never activates it.
        rep(8'h02, 8'h02, 1'b0, 1'b0, 2);
        rep(8'h02, 8'h00, 1'b0, 1'b0, 4);
        rep(8'h00, 8'h00, 1'b0, 1'b0, 2);
        // Neighbour exclusion around an active channel 0.
        rep(8'h01, 8'h01, 1'b0, 1'b0, 4);
        rep(8'h87, 8'h04, 1'b0, 1'b0, 6);
        rep(8'h00, 8'h00, 1'b0, 1'b0, 20);
        // Round-robin: channels 2 and 5 become candidates on the same edge.
        rep(8'h00, 8'h00, 1'b0, 1'b1, 1);
        rep(8'h24, 8'h24, 1'b0, 1'b0, 6);
        rep(8'h00, 8'h00, 1'b0, 1'b0, 20);
        // Fault: grant on channel 4 next to active channel 3, then clear and resume.
        rep(8'h08, 8'h08, 1'b0, 1'b0, 4);
        rep(8'h08, 8'h18, 1'b0, 1'b0, 1);
        rep(8'h00, 8'h00, 1'b0, 1'b0, 2);
        rep(8'h00, 8'h00, 1'b1, 1'b0, 1);
        rep(8'h01, 8'h01, 1'b0, 1'b0, 5);
        rep(8'h00, 8'h00, 1'b0, 1'b0, 20);
        // Fault and clear on the same edge: the fault wins.
        rep(8'h01, 8'h01, 1'b0, 1'b0, 4);
        rep(8'h01, 8'h03, 1'b1, 1'b0, 1);
        rep(8'h00, 8'h00, 1'b1, 1'b0, 1);
        // Long hold on channel 6 (watchdog trip when that feature is built in).
        rep(8'h00, 8'h00, 1'b0, 1'b1, 1);
        rep(8'h40, 8'h40, 1'b0, 1'b0, 30);
        rep(8'h00, 8'h00, 1'b0, 1'b0, 2);
        rep(8'h40, 8'h40, 1'b0, 1'b0, 10);
        rep(8'h00, 8'h00, 1'b0, 1'b0, 20);

        // Random traffic with sticky requests, mostly legal grants and rare faults.
        rq = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) rq[i] = ~rq[i];
            end
            gn = rq;
            for (int i = 0; i < N; i++) begin
                if (!m_on[i] && (m_on[nb_lo(i)] || m_on[nb_hi(i)])) gn[i] = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) gn = gn & 8'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                pick = 3'($urandom_range(0, 7));
                gn[pick] = 1'b1;
            end
            cl = m_fault && ($urandom_range(0, 5) == 0);
            rr = ($urandom_range(0, 499) == 0);
            step(rq, gn, cl, rr);
        end
        rep(8'h00, 8'h00, 1'b0, 1'b0, 2);

        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ring_interlock_feedback.md
Name: ring_interlock_feedback

Overview:
- Downstream stage of the ring interlock combinational logic (channels A..H).
- Consumes per-channel requests and interlock grant bits. Qualifies each grant, arbitrates channel activation, and enforces minimum hold time.
- Drives the registered feedback vector (the A1..H1 signals) that loops back into the interlock logic.
- Detects neighbour-exclusion violations reported by the interlock logic and latches a sticky fault.

Parameters:
- N_CH, 8, number of ring channels; index 0 = A ... 7 = H. Channel i's neighbours are (i-1) mod N_CH and (i+1) mod N_CH.
- DEBOUNCE, 3, consecutive cycles req&grant must be high before activation (>=1).
- MIN_HOLD, 16, minimum cycles a channel's feedback stays high once active (>=1).
- CNT_W, 8, per-channel counter width; must hold max(DEBOUNCE, MIN_HOLD, MAX_ACTIVE).
- MAX_ACTIVE, 200, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset.
- i_req  in  N_CH  raw channel requests.
- i_grant  in  N_CH  combinational grant from the interlock logic.
- i_fault_clr  in  1  clears the sticky fault.
- o_fb  out  N_CH  registered feedback; 1 while the channel is ACTIVE or RELEASE.
- o_busy  out  1  OR of all channels not in IDLE.
- o_fault  out  1  sticky neighbour-violation flag.
- o_fault_ch  out  $clog2(N_CH)  index of the faulting channel.
- o_wd_trip  out  N_CH  watchdog trip pulses; port present only with the optional feature.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst). rst=1 at a rising edge puts everything in reset, including mid-operation.
- Reset values:
  - All channels IDLE, all counters 0.
  - Round-robin pointer rr=0.
  - o_fb=0, o_busy=0, o_fault=0, o_fault_ch=0, o_wd_trip=0.
- Per-channel FSM (q = i_req[i] & i_grant[i]):
  - IDLE: fb=0. If q, go to QUAL with cnt=1.
  - QUAL: fb=0.
    - If !q, go to IDLE and clear cnt.
    - Else if cnt<DEBOUNCE, cnt+1.
    - Else (cnt==DEBOUNCE) the channel is a candidate. If eligible and it wins arbitration, go to ACTIVE with cnt=0. Otherwise wait in QUAL, cnt saturated.
  - ACTIVE: fb=1, cnt+1 (saturating).
    - If !i_req and cnt>=MIN_HOLD, go to IDLE.
    - If !i_req and cnt<MIN_HOLD, go to RELEASE.
  - RELEASE: fb=1, cnt+1.
    - If i_req, return to ACTIVE; cnt is not cleared and no re-qualification occurs.
    - Else if cnt>=MIN_HOLD, go to IDLE.
  - i_grant is ignored in ACTIVE and RELEASE except for fault detection.
- Latency: with req&grant first sampled high at edge k and held, o_fb[i] rises after edge k+DEBOUNCE, provided the channel is eligible and wins. After ACTIVE entry at edge a, o_fb[i] falls no earlier than after edge a+MIN_HOLD.
- Eligibility: neither neighbour is in ACTIVE or RELEASE, evaluated on current (pre-edge) state.
- Arbitration:
  - At most one channel enters ACTIVE per edge.
  - The winner is the first eligible candidate scanning upward from rr, mod N_CH.
  - On a win, rr = winner+1 mod N_CH; otherwise rr holds.
- Fault:
  - Condition: at an edge, i_grant[j]=1 while channel j is IDLE or QUAL and a neighbour of j is in ACTIVE or RELEASE.
  - Response: o_fault=1; all channels forced to IDLE and counters cleared (o_fb=0 next cycle).
  - o_fault_ch takes the lowest offending j, only on the 0->1 transition of o_fault.
  - While o_fault=1, no channel leaves IDLE.
  - i_fault_clr=1 clears o_fault. A new fault condition in the same cycle wins over the clear.
- Counters saturate at 2^CNT_W-1; no wrap.

Optional Feature:
- Macro: RING_ILOCK_WATCHDOG_EN.
- Defined:
  - A channel continuously in ACTIVE/RELEASE for MAX_ACTIVE cycles is forced to IDLE and pulses o_wd_trip[i] for one cycle.
  - The channel is then locked out, ignoring q, until i_req[i] is sampled low at least once.
  - The residence counter is independent of cnt and resets on IDLE.
- Undefined:
  - No o_wd_trip port and no watchdog logic.
  - Channels may stay active indefinitely.

Test Plan:
- Reset: rst=1 for 2 edges with i_req=FF, i_grant=FF -> o_fb=00, o_busy=0, o_fault=0, o_fault_ch=0. After release, the first activation is channel 0.
- Debounce/hold: req[0]=grant[0]=1 sampled from edge 10 -> o_fb=01 after edge 13. Drop req[0] at edge 15 -> o_fb[0] stays 1 until after edge 29. A 2-cycle grant glitch on channel 1 never sets o_fb[1].
- Neighbour exclusion: ch0 active; req[1]=req[7]=req[2]=1 with grant=04 -> only o_fb[2] rises (edge k+3); ch1 and ch7 stay 0.
- Round-robin: ch2 and ch5 both reach cnt==DEBOUNCE at the same edge, rr=0 -> ch2 activates that edge, ch5 the next edge; rr=6 afterwards.
- Fault: ch3 ACTIVE, drive grant[4]=1 with ch4 IDLE -> next edge o_fault=1, o_fault_ch=4, o_fb=00. Pulse i_fault_clr -> o_fault=0 and normal activation resumes.
- Watchdog (RING_ILOCK_WATCHDOG_EN, MAX_ACTIVE=20): hold req[6]=grant[6]=1 -> o_fb[6] drops 20 cycles after activation, o_wd_trip=40 for one cycle. The channel does not re-activate until req[6] is deasserted and then reasserted.
